// File: rtl/count_rate_sampler_if.sv
`default_nettype none
// ============================================================================
// Module   : count_rate_sampler_if
// Brief    : Valid/ready sample stream carrying {delta, ovf, seq}.
// Revision : 1.0 - initial release
// ============================================================================
interface count_rate_sampler_if #(
    parameter int WIDTH = 8
);
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_delta;
    logic             m_ovf;
    logic [3:0]       m_seq;

    modport master (
        output m_valid,
        output m_delta,
        output m_ovf,
        output m_seq,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_delta,
        input  m_ovf,
        input  m_seq,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/count_rate_sampler.sv
`default_nettype none
// ============================================================================
// Module   : count_rate_sampler
// Brief    : Samples an up counter once per window, queues the increment.
// Revision : 1.0 - initial release
// ============================================================================
module count_rate_sampler #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 100,
    parameter int DEPTH  = 4
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    input  wire logic [WIDTH-1:0]        count_in,
    input  wire logic                    count_en,
    count_rate_sampler_if.master         m,
    output logic [$clog2(DEPTH):0]       level,
    output logic [7:0]                   drop_cnt
);

    localparam int c_TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_DW = WIDTH + 5;
    localparam logic [c_TW-1:0]  c_TIMER_MAX = c_TW'(WINDOW - 1);
    localparam logic [WIDTH:0]   c_EVT_SAT   = {1'b1, {WIDTH{1'b0}}};
    localparam logic [c_AW:0]    c_FULL      = (c_AW + 1)'(DEPTH);

    logic [c_TW-1:0]  r_timer;
    logic [WIDTH-1:0] r_last;
    logic [WIDTH:0]   r_evt;
    logic [3:0]       r_seq;
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_level;
    logic [7:0]       r_drop;
    logic [c_DW-1:0]  r_mem [DEPTH];

    logic             w_sample;
    logic             w_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [WIDTH-1:0] w_delta;
    logic             w_ovf;
    logic [c_DW-1:0]  w_head;

    assign w_sample = (r_timer == c_TIMER_MAX);
    assign w_valid  = (r_level != '0);
    assign w_pop    = w_valid && m.m_ready;
    // A full FIFO still accepts a sample when the head leaves on the same edge.
    assign w_push   = w_sample && ((r_level != c_FULL) || w_pop);
    assign w_drop   = w_sample && !w_push;
    assign w_delta  = count_in - r_last;
    assign w_ovf    = (r_evt == c_EVT_SAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
            r_last  <= '0;
            r_evt   <= '0;
            r_seq   <= '0;
        end else if (w_sample) begin
            r_timer <= '0;
            r_last  <= count_in;
            // This edge's enable is not yet reflected in count_in, so it
            // opens the next window's event tally.
            r_evt   <= (WIDTH + 1)'(count_en);
            r_seq   <= r_seq + 4'd1;
        end else begin
            r_timer <= r_timer + c_TW'(1);
            if (count_en && (r_evt != c_EVT_SAT)) begin
                r_evt <= r_evt + (WIDTH + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_delta, w_ovf, r_seq};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_drop  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_AW + 1)'(1);
                2'b01:   r_level <= r_level - (c_AW + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign w_head    = r_mem[r_rptr];
    assign m.m_valid = w_valid;
    assign m.m_delta = w_valid ? w_head[c_DW-1:5] : '0;
    assign m.m_ovf   = w_valid ? w_head[4]        : 1'b0;
    assign m.m_seq   = w_valid ? w_head[3:0]      : 4'd0;
    assign level     = r_level;
    assign drop_cnt  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_count_rate_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_rate_sampler
// Brief    : Self-checking bench: scoreboard on the sample stream plus vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_rate_sampler;

    localparam int WIN = 100;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] cnt;
    logic [2:0] level;
    logic [7:0] drop_cnt;
    logic [2:0] level3;
    logic [7:0] drop3;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    // Upstream up counter sharing the sampler's reset and enable.
    always_ff @(posedge clk) begin
        if (reset)   cnt <= 8'd0;
        else if (en) cnt <= cnt + 8'd1;
    end

    count_rate_sampler_if #(.WIDTH(8)) bus ();
    count_rate_sampler_if #(.WIDTH(8)) bus3 ();
    assign bus.m_ready  = rdy;
    assign bus3.m_ready = 1'b1;

    count_rate_sampler #(.WIDTH(8), .WINDOW(WIN), .DEPTH(DEP)) dut (
        .clk(clk), .reset(reset), .count_in(cnt), .count_en(en),
        .m(bus), .level(level), .drop_cnt(drop_cnt)
    );

    count_rate_sampler #(.WIDTH(8), .WINDOW(300), .DEPTH(DEP)) dut300 (
        .clk(clk), .reset(reset), .count_in(cnt), .count_en(en),
        .m(bus3), .level(level3), .drop_cnt(drop3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: the queue itself models FIFO contents; expectations come
    // from an unbounded running total of enable cycles.
    typedef struct {
        logic [7:0] delta;
        logic       ovf;
        logic [3:0] seq;
    } samp_t;

    samp_t q[$];
    int    ecount = 0;
    int    ctot   = 0;
    int    clast  = 0;
    int    mseq   = 0;
    int    mdrop  = 0;

    initial begin
        samp_t s;
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                ecount = 0; ctot = 0; clast = 0; mseq = 0; mdrop = 0;
            end else begin
                if (q.size() > 0 && rdy) void'(q.pop_front());
                ecount++;
                if (ecount % WIN == 0) begin
                    s.delta = 8'(ctot - clast);
                    s.ovf   = (ctot - clast) >= 256;
                    s.seq   = 4'(mseq);
                    mseq    = mseq + 1;
                    clast   = ctot;
                    if (q.size() < DEP) q.push_back(s);
                    else if (mdrop < 255) mdrop++;
                end
                if (en) ctot++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("sb_valid", 32'(bus.m_valid), 32'(q.size() > 0));
                chk("sb_level", 32'(level), 32'(q.size()));
                chk("sb_drop", 32'(drop_cnt), 32'(mdrop));
                if (q.size() > 0) begin
                    chk("sb_delta", 32'(bus.m_delta), 32'(q[0].delta));
                    chk("sb_ovf", 32'(bus.m_ovf), 32'(q[0].ovf));
                    chk("sb_seq", 32'(bus.m_seq), 32'(q[0].seq));
                end else begin
                    chk("idle_delta", 32'(bus.m_delta), 32'd0);
                    chk("idle_ovf", 32'(bus.m_ovf), 32'd0);
                    chk("idle_seq", 32'(bus.m_seq), 32'd0);
                end
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(1);
        reset = 1'b0;
    endtask

    typedef struct {
        bit rst;
        bit en;
        bit rdy;
        int cycles;
        bit valid;
        int lvl;
        int drop;
        int seq;
        int delta;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // rst en rdy cycles | valid lvl drop seq delta
        vecs[0] = '{1, 1, 1, 100, 1, 1, 0, 0, 99};
        vecs[1] = '{0, 1, 1, 100, 1, 1, 0, 1, 100};
        vecs[2] = '{0, 1, 1, 100, 1, 1, 0, 2, 100};
        vecs[3] = '{1, 0, 1, 100, 1, 1, 0, 0, 0};
        vecs[4] = '{0, 0, 1, 100, 1, 1, 0, 1, 0};
        vecs[5] = '{0, 0, 1, 100, 1, 1, 0, 2, 0};
        vecs[6] = '{1, 1, 0, 600, 1, 4, 2, 0, 99};
        vecs[7] = '{0, 1, 1, 4,   0, 0, 2, 0, 0};
        vecs[8] = '{0, 1, 1, 96,  1, 1, 2, 6, 100};

        @(negedge clk);
        chk_on = 1'b1;
        reset  = 1'b0;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rst) do_reset();
            en  = vecs[i].en;
            rdy = vecs[i].rdy;
            run(vecs[i].cycles);
            chk("vec_valid", 32'(bus.m_valid), 32'(vecs[i].valid));
            chk("vec_level", 32'(level), 32'(vecs[i].lvl));
            chk("vec_drop", 32'(drop_cnt), 32'(vecs[i].drop));
            chk("vec_seq", 32'(bus.m_seq), 32'(vecs[i].seq));
            chk("vec_delta", 32'(bus.m_delta), 32'(vecs[i].delta));
        end

        // Long window: 299 then 300 events both exceed the 8-bit range.
        do_reset();
        en = 1'b1; rdy = 1'b1;
        run(300);
        chk("w300_valid", 32'(bus3.m_valid), 32'd1);
        chk("w300_ovf0", 32'(bus3.m_ovf), 32'd1);
        chk("w300_delta0", 32'(bus3.m_delta), 32'd43);
        chk("w300_seq0", 32'(bus3.m_seq), 32'd0);
        run(300);
        chk("w300_ovf1", 32'(bus3.m_ovf), 32'd1);
        chk("w300_delta1", 32'(bus3.m_delta), 32'd44);
        chk("w300_seq1", 32'(bus3.m_seq), 32'd1);

        // Full FIFO with a single-cycle pop landing on the sample edge.
        do_reset();
        en = 1'b1; rdy = 1'b0;
        run(499);
        chk("full_level", 32'(level), 32'd4);
        rdy = 1'b1;
        run(1);
        rdy = 1'b0;
        chk("pp_level", 32'(level), 32'd4);
        chk("pp_drop", 32'(drop_cnt), 32'd0);
        chk("pp_head", 32'(bus.m_seq), 32'd1);
        rdy = 1'b1;
        run(3);
        rdy = 1'b0;
        chk("tail_seq", 32'(bus.m_seq), 32'd4);
        chk("tail_delta", 32'(bus.m_delta), 32'd100);
        chk("tail_level", 32'(level), 32'd1);

        // Reset with three entries queued and one drop recorded.
        do_reset();
        en = 1'b1; rdy = 1'b0;
        run(500);
        rdy = 1'b1;
        run(1);
        rdy = 1'b0;
        chk("pre_level", 32'(level), 32'd3);
        chk("pre_drop", 32'(drop_cnt), 32'd1);
        do_reset();
        chk("rst_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        run(100);
        chk("post_seq", 32'(bus.m_seq), 32'd0);
        chk("post_delta", 32'(bus.m_delta), 32'd99);
        chk("post_valid", 32'(bus.m_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
